instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage feeding `instruction_decode`. It issues word reads to instruction memory with a req/ack handshake and keeps one request outstanding at most. Returned words are buffered with their PCs in a small FIFO, and the FIFO head is presented to decode as `instr_valid_o`/`instr_o`/`pc_o`. Execute redirects fetch on taken branches; a redirect flushes buffered wrong-path words and discards any in-flight read.

## Interface
- `DEPTH`, default 2: FIFO entries, power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets).
- `imem_req_o`  out  1  read request.
- `imem_addr_o`  out  32  word address; bits [1:0] always 0.
- `imem_ack_i`  in  1  read complete; `imem_data_i` valid this cycle.
- `imem_data_i`  in  32  instruction word.
- `redirect_i`  in  1  branch taken; fetch restarts at `redirect_pc_i`.
- `redirect_pc_i`  in  32  target; bits [1:0] ignored and forced to 0.
- `stall_i`  in  1  decode not accepting this cycle.
- `instr_valid_o`  out  1  `instr_o`/`pc_o` valid.
- `instr_o`  out  32  head instruction; 32'hE320_F000 (AL NOP) when not valid.
- `pc_o`  out  32  address of head instruction; 0 when not valid.

## Operation
- State: `pc` (next fetch address), `stale_addr`, FIFO of {pc, instr} with `count`, and an FSM with states IDLE, FETCH and DRAIN.
- Reset values: state IDLE, `pc`=RESET_PC, `count`=0, `imem_req_o`=0, `imem_addr_o`=0, `instr_valid_o`=0, `instr_o`=32'hE320_F000, `pc_o`=0.
- `imem_req_o` = (state is FETCH or DRAIN). `imem_addr_o` = `pc` in FETCH, `stale_addr` in DRAIN, 0 in IDLE.
- Memory protocol: once `imem_req_o` rises, it and `imem_addr_o` hold until a cycle with `imem_ack_i`=1. The ack may come in the same cycle as the request. `imem_ack_i` outside a request is ignored.
- Pop: `instr_valid_o` && !`stall_i` removes the head.
- `instr_valid_o` = (`count`≠0) && !`redirect_i`.
- IDLE: go to FETCH when `count_next` < DEPTH.
- FETCH, ack and no redirect: push {`pc`, `imem_data_i`} and set `pc` += 4 (wraps modulo 2^32). Stay in FETCH if `count_next` < DEPTH, else go to IDLE.
- FETCH, ack and redirect: discard the data, set `pc` = redirect target, flush the FIFO, stay in FETCH.
- FETCH, redirect and no ack: `stale_addr` ← `pc`, `pc` ← target, flush, go to DRAIN.
- FETCH, neither: hold.
- DRAIN, ack: discard the data, go to FETCH. A redirect in the same cycle updates `pc` only.
- DRAIN, redirect and no ack: update `pc` and stay in DRAIN.
- Issue rule: a request starts only when `count` < DEPTH. Because only one request is ever outstanding, a push never finds the FIFO full.
- Push and pop in the same cycle: `count` is unchanged and the FIFO pointers wrap modulo DEPTH.
- Redirect in any state, including IDLE: flush the FIFO (`count`=0) and load `pc`. From IDLE, go to FETCH.
- Asserting `rst` at any time, including mid-request or in DRAIN, returns all state to reset values immediately. The memory side must drop any pending ack.

## Timing
- First request is in the 2nd cycle after `rst` deasserts (IDLE → FETCH at the first edge).
- Ack in cycle N (no stall, no redirect): `instr_valid_o` is 1 in cycle N+1. The next request starts in cycle N+1.
- Back-to-back zero-wait memory gives one instruction per cycle.
- Redirect in cycle N: `instr_valid_o`=0 in cycle N. If no read was outstanding, or the ack arrived in cycle N, the request at the target starts in N+1.
- Outstanding read with ack in cycle M > N: the target request starts in M+1.
- Decode stalled with the FIFO full: `imem_req_o`=0. The first pop returns the FSM to FETCH on the next edge.

## Test plan
- Reset and streaming: RESET_PC=0x100, zero-wait memory returning addr^0xA5A5_0000. Required: req at cycle 2; `pc_o` = 0x100, 0x104, 0x108… with `instr_valid_o` continuous from cycle 3.
- Backpressure: hold `stall_i`=1 for 6 cycles. Required: `count` reaches DEPTH, `imem_req_o`=0, head stays at 0x100. On release, words 0x100, 0x104 and then 0x108 follow with no gap or duplicate.
- Redirect with read in flight: memory with 3-cycle latency; `redirect_i` to 0x2002 one cycle after the request to 0x10C. Required: `imem_addr_o` holds 0x10C until ack; that data is never output; the next request uses 0x2000; the first valid `pc_o` is 0x2000.
- Redirect coincident with ack: required that the acked word is discarded and the request to the target starts the next cycle.
- Wrap-around: redirect to 0xFFFF_FFFC. Required: the next fetch address is 0x0000_0000.
- Mid-operation reset: assert `rst`=0 while in DRAIN. Required: outputs take reset values asynchronously; after release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction memory read bus: one word request held until acked.
interface instruction_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: single outstanding imem read, small {pc, instr} FIFO towards decode,
// redirect flushes buffered words and drains any in-flight read.
module instruction_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        imem,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       stall_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [31:0]       NOP   = 32'hE320_F000;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state, state_next;
    logic [31:0]        pc, stale_addr, target;
    logic [CNT_W-1:0]   count, count_next;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [31:0]        fifo_pc    [DEPTH];
    logic [31:0]        fifo_instr [DEPTH];
    logic               push, pop, abandon;
    logic               unused_pc_low;

    assign target        = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_low = ^redirect_pc_i[1:0];

    assign instr_valid_o = (count != '0) && !redirect_i;
    assign pop           = instr_valid_o && !stall_i;
    assign push          = (state == FETCH) && imem.imem_ack_i && !redirect_i;
    // Redirect while our read is still pending: remember its address so the bus stays stable.
    assign abandon       = (state == FETCH) && redirect_i && !imem.imem_ack_i;

    assign instr_o = instr_valid_o ? fifo_instr[rd_ptr] : NOP;
    assign pc_o    = instr_valid_o ? fifo_pc[rd_ptr]    : 32'h0;

    always_comb begin
        count_next = count;
        if (redirect_i)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (count_next < FULL) state_next = FETCH;
            FETCH: begin
                if (imem.imem_ack_i) begin
                    if (!redirect_i && !(count_next < FULL))
                        state_next = IDLE;
                end else if (redirect_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: if (imem.imem_ack_i) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = 32'h0;
        case (state)
            FETCH: begin
                imem.imem_req_o  = 1'b1;
                imem.imem_addr_o = pc;
            end
            DRAIN: begin
                imem.imem_req_o  = 1'b1;
                imem.imem_addr_o = stale_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (redirect_i)
                pc <= target;
            else if (push)
                pc <= pc + 32'd4;
            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage carries no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem.imem_data_i;
        end
        if (abandon)
            stale_addr <= pc;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a transaction-level model.
module tb_instruction_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'hE320_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    instruction_fetch_if bus ();

    instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic        stall, redir;
    logic [31:0] redir_pc;
    int          lat, waited;
    bit          mem_rand, spurious;

    logic [63:0] q [$];
    logic [31:0] m_pc, m_addr;
    bit          m_busy, m_wrong;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = RESET_PC;
        m_busy  = 1'b0;
        m_wrong = 1'b0;
    endtask

    // Assert reset (outputs must react without a clock edge), then release on a negedge.
    task automatic do_reset();
        rst               = 1'b0;
        redirect_i        = 1'b0;
        stall_i           = stall;
        bus.imem_ack_i    = 1'b0;
        bus.imem_data_i   = 32'h0;
        waited            = 0;
        #1;
        chk("rst_req",   {31'b0, bus.imem_req_o}, 32'h0);
        chk("rst_addr",  bus.imem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc",    pc_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic step();
        logic        m_valid, ack;
        logic [63:0] head;
        cyc++;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        if (bus.imem_req_o === 1'b1)
            ack = (waited >= lat);
        else
            ack = spurious && ($urandom_range(0, 3) == 0);
        bus.imem_ack_i  = ack;
        bus.imem_data_i = (bus.imem_req_o === 1'b1) ? (bus.imem_addr_o ^ KEY) : $urandom();
        #1;
        m_valid = (q.size() != 0) && !redir;
        head    = m_valid ? q[0] : {32'h0, NOP};
        chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, m_valid});
        chk("instr",       instr_o, head[31:0]);
        chk("pc",          pc_o, head[63:32]);
        chk("req",         {31'b0, bus.imem_req_o}, {31'b0, m_busy});
        chk("addr",        bus.imem_addr_o, m_busy ? m_addr : 32'h0);
        if (bus.imem_req_o === 1'b1) begin
            if (ack) begin
                waited = 0;
                if (mem_rand) lat = $urandom_range(0, 3);
            end else begin
                waited++;
            end
        end
        // Model: pop, retire the outstanding read, apply redirect, then maybe issue.
        if (m_valid && !stall) void'(q.pop_front());
        if (m_busy && ack) begin
            if (!m_wrong && !redir) begin
                q.push_back({m_addr, m_addr ^ KEY});
                m_pc = m_addr + 32'd4;
            end
            m_busy = 1'b0;
        end
        if (redir) begin
            q.delete();
            m_pc = redir_pc & 32'hFFFF_FFFC;
            if (m_busy) m_wrong = 1'b1;
        end
        if (!m_busy && q.size() < DEPTH) begin
            m_busy  = 1'b1;
            m_addr  = m_pc;
            m_wrong = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget);
        int n = 0;
        while (!(bus.imem_req_o === 1'b1 && bus.imem_addr_o === a) && n < budget) begin
            step();
            n++;
        end
        chk("reach_addr", (bus.imem_req_o === 1'b1) ? bus.imem_addr_o : 32'hDEAD_DEAD, a);
    endtask

    task automatic wait_valid(input logic [31:0] exp_pc, input int budget);
        int n = 0;
        while (instr_valid_o !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("first_valid_pc", (instr_valid_o === 1'b1) ? pc_o : 32'hDEAD_DEAD, exp_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        lat = 0; waited = 0; mem_rand = 1'b0; spurious = 1'b0;
        redirect_pc_i = 32'h0;

        // Reset and zero-wait streaming
        do_reset();
        chk("c1_req", {31'b0, bus.imem_req_o}, 32'h0);
        step();
        chk("c2_req",  {31'b0, bus.imem_req_o}, 32'h1);
        chk("c2_addr", bus.imem_addr_o, 32'h0000_0100);
        step();
        chk("c3_valid", {31'b0, instr_valid_o}, 32'h1);
        chk("c3_pc",    pc_o, 32'h0000_0100);
        chk("c3_instr", instr_o, 32'hA5A5_0100);
        step();
        chk("c4_pc", pc_o, 32'h0000_0104);
        step();
        chk("c5_pc", pc_o, 32'h0000_0108);
        repeat (4) step();

        // Backpressure from the first cycle
        stall = 1'b1;
        do_reset();
        repeat (7) step();
        chk("bp_req",   {31'b0, bus.imem_req_o}, 32'h0);
        chk("bp_valid", {31'b0, instr_valid_o}, 32'h1);
        chk("bp_head",  pc_o, 32'h0000_0100);
        stall = 1'b0;
        step();
        chk("bp_pc1", pc_o, 32'h0000_0104);
        step();
        chk("bp_pc2", pc_o, 32'h0000_0108);
        repeat (3) step();

        // Redirect while a 3-cycle read is in flight
        lat = 3;
        do_reset();
        wait_addr(32'h0000_010C, 60);
        step();
        redir = 1'b1; redir_pc = 32'h0000_2002;
        step();
        redir = 1'b0;
        chk("drain_addr1", bus.imem_addr_o, 32'h0000_010C);
        chk("drain_req1",  {31'b0, bus.imem_req_o}, 32'h1);
        step();
        chk("drain_addr2", bus.imem_addr_o, 32'h0000_010C);
        step();
        chk("target_addr", bus.imem_addr_o, 32'h0000_2000);
        wait_valid(32'h0000_2000, 20);

        // Enter DRAIN again, then reset asynchronously mid-cycle
        redir = 1'b1; redir_pc = 32'h0000_3000;
        step();
        redir = 1'b0;
        chk("pre_rst_req",  {31'b0, bus.imem_req_o}, 32'h1);
        chk("pre_rst_addr", bus.imem_addr_o, 32'h0000_2004);
        #2;
        lat = 0;
        do_reset();
        step();
        chk("post_rst_addr", bus.imem_addr_o, RESET_PC);
        repeat (3) step();

        // Redirect coincident with a zero-wait ack
        redir = 1'b1; redir_pc = 32'h0000_4000;
        step();
        redir = 1'b0;
        chk("coin_addr", bus.imem_addr_o, 32'h0000_4000);
        step();
        chk("coin_valid", {31'b0, instr_valid_o}, 32'h1);
        chk("coin_pc",    pc_o, 32'h0000_4000);
        chk("coin_instr", instr_o, 32'hA5A5_4000);

        // Address wrap-around; low target bits ignored
        redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
        step();
        redir = 1'b0;
        chk("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", bus.imem_addr_o, 32'h0000_0000);
        chk("wrap_pc0",   pc_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc1",   pc_o, 32'h0000_0000);

        // Random traffic: variable latency, stray acks, stalls and redirects
        mem_rand = 1'b1;
        spurious = 1'b1;
        for (int blk = 0; blk < 3; blk++) begin
            stall = 1'b0;
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                stall = ($urandom_range(0, 99) < 30);
                redir = ($urandom_range(0, 99) < 5);
                redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                       : $urandom();
                step();
            end
        end
        stall = 1'b0;
        redir = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
